// File: rtl/commit_trace_buffer_pkg.sv
// rtl/commit_trace_buffer_pkg.sv - shared types for the commit trace buffer
package commit_trace_buffer_pkg;

    localparam int TRACE_SEQ_W = 32;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] instr_t;
    typedef logic [31:0] data_t;
    typedef logic [4:0]  reg_idx_t;

    typedef struct packed {
        logic [TRACE_SEQ_W-1:0] seq;
        addr_t                  pc;
        instr_t                 instr;
        reg_idx_t               rd;
        logic                   rd_we;
        data_t                  rd_value;
        logic                   mem_we;
        addr_t                  mem_addr;
        data_t                  mem_data;
    } trace_rec_t;

    // x0 is hardwired to zero, so a "write" to it is not a real register update
    function automatic trace_rec_t make_rec(
        input logic [TRACE_SEQ_W-1:0] seq,
        input addr_t                  pc,
        input instr_t                 instr,
        input reg_idx_t               rd,
        input logic                   rd_we,
        input data_t                  rd_value,
        input logic                   mem_we,
        input addr_t                  mem_addr,
        input data_t                  mem_data
    );
        trace_rec_t r;
        r.seq      = seq;
        r.pc       = pc;
        r.instr    = instr;
        r.rd       = rd;
        r.rd_we    = rd_we & (rd != 5'd0);
        r.rd_value = rd_value;
        r.mem_we   = mem_we;
        r.mem_addr = mem_addr;
        r.mem_data = mem_data;
        return r;
    endfunction

endpackage

// File: rtl/commit_trace_buffer_if.sv
// rtl/commit_trace_buffer_if.sv - commit input and trace output handshake bundle
interface commit_trace_buffer_if;
    import commit_trace_buffer_pkg::*;

    logic       commit_valid;
    addr_t      commit_pc;
    instr_t     commit_instr;
    reg_idx_t   commit_rd;
    logic       commit_rd_we;
    data_t      commit_rd_value;
    logic       commit_mem_we;
    addr_t      commit_mem_addr;
    data_t      commit_mem_data;

    logic       trace_valid;
    logic       trace_ready;
    trace_rec_t trace_rec;

    // core / consumer side
    modport master (
        output commit_valid, commit_pc, commit_instr, commit_rd, commit_rd_we,
               commit_rd_value, commit_mem_we, commit_mem_addr, commit_mem_data,
        output trace_ready,
        input  trace_valid, trace_rec
    );

    // trace buffer side
    modport slave (
        input  commit_valid, commit_pc, commit_instr, commit_rd, commit_rd_we,
               commit_rd_value, commit_mem_we, commit_mem_addr, commit_mem_data,
        input  trace_ready,
        output trace_valid, trace_rec
    );
endinterface

// File: rtl/commit_trace_buffer_fifo_mem.sv
// rtl/commit_trace_buffer_fifo_mem.sv - record storage, one write port, async read
module commit_trace_buffer_fifo_mem
    import commit_trace_buffer_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  trace_rec_t               wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output trace_rec_t               rdata
);

    trace_rec_t mem [DEPTH];

    // storage is deliberately not reset; the top masks the head while empty
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/commit_trace_buffer.sv
// rtl/commit_trace_buffer.sv - retire trace capture FIFO with sequence stamping
module commit_trace_buffer
    import commit_trace_buffer_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int SEQ_W  = TRACE_SEQ_W,
    parameter int DROP_W = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     flush,
    commit_trace_buffer_if.slave     bus,
    output logic [$clog2(DEPTH):0]   fill_level,
    output logic [DROP_W-1:0]        drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [SEQ_W-1:0] seq_cnt;
    logic             empty;
    logic             full;
    logic             push;
    logic             pop;
    logic             drop;
    trace_rec_t       wdata;
    trace_rec_t       rdata;

    // extra pointer MSB distinguishes full from empty when the low bits match
    always_comb begin
        empty = (wr_ptr == rd_ptr);
        full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        pop   = !empty && bus.trace_ready && !flush;
        push  = bus.commit_valid && (!full || pop) && !flush;
        drop  = bus.commit_valid && full && !pop && !flush;
        wdata = make_rec(TRACE_SEQ_W'(seq_cnt), bus.commit_pc, bus.commit_instr,
                         bus.commit_rd, bus.commit_rd_we, bus.commit_rd_value,
                         bus.commit_mem_we, bus.commit_mem_addr, bus.commit_mem_data);
    end

    commit_trace_buffer_fifo_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (wdata),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (rdata)
    );

    // pointer advance; flush empties the queue without touching storage
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // every retire consumes a number, so gaps downstream reveal lost records
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seq_cnt <= '0;
        end else if (bus.commit_valid) begin
            seq_cnt <= seq_cnt + SEQ_W'(1);
        end
    end

    // saturating count of records refused by a full queue
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_count <= '0;
        end else if (drop && (drop_count != {DROP_W{1'b1}})) begin
            drop_count <= drop_count + DROP_W'(1);
        end
    end

    // show-ahead head; zeroed while empty so stale storage never appears
    always_comb begin
        fill_level      = wr_ptr - rd_ptr;
        bus.trace_valid = !empty;
        bus.trace_rec   = empty ? '0 : rdata;
    end

endmodule

// File: tb/tb_commit_trace_buffer.sv
// tb/tb_commit_trace_buffer.sv - self-checking bench for commit_trace_buffer
module tb_commit_trace_buffer;
    import commit_trace_buffer_pkg::*;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        flush = 1'b0;
    logic [3:0]  fill_level;
    logic [15:0] drop_count;

    int n_checks = 0;
    int n_pass   = 0;

    trace_rec_t  mq[$];
    int unsigned m_seq  = 0;
    int unsigned m_drop = 0;

    commit_trace_buffer_if bus();

    commit_trace_buffer #(
        .DEPTH  (DEPTH),
        .SEQ_W  (32),
        .DROP_W (16)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .flush      (flush),
        .bus        (bus),
        .fill_level (fill_level),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          cv;
        logic [31:0] pc;
        logic [4:0]  rd;
        bit          rd_we;
        logic [31:0] val;
        bit          ready;
        bit          fl;
        bit          e_valid;
        int          e_fill;
        int          e_seq;
        logic [31:0] e_pc;
        bit          e_rd_we;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic chk_rec(input string name, input trace_rec_t act, input trace_rec_t exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic model_check();
        trace_rec_t e;
        e = (mq.size() > 0) ? mq[0] : '0;
        chk("model_valid", 32'(bus.trace_valid), 32'(mq.size() > 0));
        chk("model_fill", 32'(fill_level), 32'(mq.size()));
        chk("model_drop", 32'(drop_count), m_drop);
        chk_rec("model_rec", bus.trace_rec, e);
    endtask

    // one clock: drive at negedge, advance the model, check at next negedge
    task automatic cycle(input bit cv, input bit rdy, input bit fl,
                         input logic [31:0] pc, input logic [4:0] rd,
                         input bit rd_we, input logic [31:0] val);
        trace_rec_t r;
        bit m_pop;
        bit m_full;
        bus.commit_valid    = cv;
        bus.commit_pc       = pc;
        bus.commit_instr    = $urandom;
        bus.commit_rd       = rd;
        bus.commit_rd_we    = rd_we;
        bus.commit_rd_value = val;
        bus.commit_mem_we   = 1'($urandom);
        bus.commit_mem_addr = $urandom;
        bus.commit_mem_data = $urandom;
        bus.trace_ready     = rdy;
        flush               = fl;
        r.seq      = m_seq;
        r.pc       = pc;
        r.instr    = bus.commit_instr;
        r.rd       = rd;
        r.rd_we    = rd_we && (rd != 5'd0);
        r.rd_value = val;
        r.mem_we   = bus.commit_mem_we;
        r.mem_addr = bus.commit_mem_addr;
        r.mem_data = bus.commit_mem_data;
        m_pop = (mq.size() > 0) && rdy && !fl;
        if (fl) begin
            mq.delete();
        end else begin
            m_full = (mq.size() == DEPTH);
            if (m_pop) void'(mq.pop_front());
            if (cv) begin
                if (!m_full || m_pop) mq.push_back(r);
                else if (m_drop != 65535) m_drop++;
            end
        end
        if (cv) m_seq++;
        @(posedge clk);
        @(negedge clk);
        bus.commit_valid = 1'b0;
        flush            = 1'b0;
        model_check();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        bus.commit_valid = 1'b0;
        bus.trace_ready  = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        mq.delete();
        m_seq  = 0;
        m_drop = 0;
    endtask

    initial begin
        bus.commit_valid = 1'b0;
        bus.commit_pc = '0; bus.commit_instr = '0; bus.commit_rd = '0;
        bus.commit_rd_we = 1'b0; bus.commit_rd_value = '0; bus.commit_mem_we = 1'b0;
        bus.commit_mem_addr = '0; bus.commit_mem_data = '0; bus.trace_ready = 1'b0;

        tbl[0] = '{1, 32'h0,  5'd1, 1, 32'h11,       1, 0, 1, 1, 0, 32'h0,  1};
        tbl[1] = '{1, 32'h4,  5'd2, 1, 32'h22,       1, 0, 1, 1, 1, 32'h4,  1};
        tbl[2] = '{1, 32'h8,  5'd3, 0, 32'h33,       1, 0, 1, 1, 2, 32'h8,  0};
        tbl[3] = '{0, 32'h0,  5'd0, 0, 32'h0,        1, 0, 0, 0, 0, 32'h0,  0};
        tbl[4] = '{1, 32'hC,  5'd0, 1, 32'hDEADBEEF, 0, 0, 1, 1, 3, 32'hC,  0};
        tbl[5] = '{1, 32'h10, 5'd5, 1, 32'h55,       0, 0, 1, 2, 3, 32'hC,  0};
        tbl[6] = '{0, 32'h0,  5'd0, 0, 32'h0,        1, 0, 1, 1, 4, 32'h10, 1};
        tbl[7] = '{0, 32'h0,  5'd0, 0, 32'h0,        1, 0, 0, 0, 0, 32'h0,  0};

        // reset state
        @(negedge clk);
        chk("rst_valid", 32'(bus.trace_valid), 32'd0);
        chk("rst_fill", 32'(fill_level), 32'd0);
        chk("rst_drop", 32'(drop_count), 32'd0);
        chk_rec("rst_rec", bus.trace_rec, '0);
        do_reset();

        // in-order delivery, one-cycle latency, rd=0 write suppression
        for (int i = 0; i < 8; i++) begin
            cycle(tbl[i].cv, tbl[i].ready, tbl[i].fl, tbl[i].pc, tbl[i].rd,
                  tbl[i].rd_we, tbl[i].val);
            chk($sformatf("tbl%0d_valid", i), 32'(bus.trace_valid), 32'(tbl[i].e_valid));
            chk($sformatf("tbl%0d_fill", i), 32'(fill_level), 32'(tbl[i].e_fill));
            if (tbl[i].e_valid) begin
                chk($sformatf("tbl%0d_seq", i), bus.trace_rec.seq, 32'(tbl[i].e_seq));
                chk($sformatf("tbl%0d_pc", i), bus.trace_rec.pc, tbl[i].e_pc);
                chk($sformatf("tbl%0d_rdwe", i), 32'(bus.trace_rec.rd_we), 32'(tbl[i].e_rd_we));
            end
        end

        // overflow: 10 commits into 8 entries, then drain
        do_reset();
        for (int i = 0; i < 10; i++) cycle(1, 0, 0, 32'(4 * i), 5'd1, 1, $urandom);
        chk("ovf_fill", 32'(fill_level), 32'd8);
        chk("ovf_drop", 32'(drop_count), 32'd2);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("drain_seq%0d", i), bus.trace_rec.seq, 32'(i));
            cycle(0, 1, 0, 0, 0, 0, 0);
        end
        chk("drain_empty", 32'(bus.trace_valid), 32'd0);
        cycle(1, 0, 0, 32'h100, 5'd2, 1, 32'h1);
        chk("post_drop_seq", bus.trace_rec.seq, 32'd10);

        // full with simultaneous push and pop
        do_reset();
        for (int i = 0; i < 8; i++) cycle(1, 0, 0, 32'(4 * i), 5'd1, 1, $urandom);
        cycle(1, 1, 0, 32'h200, 5'd3, 1, 32'h2);
        chk("fullpp_fill", 32'(fill_level), 32'd8);
        chk("fullpp_head", bus.trace_rec.seq, 32'd1);
        chk("fullpp_drop", 32'(drop_count), 32'd0);
        for (int i = 0; i < 7; i++) cycle(0, 1, 0, 0, 0, 0, 0);
        chk("fullpp_tail", bus.trace_rec.seq, 32'd8);
        chk("fullpp_tailpc", bus.trace_rec.pc, 32'h200);

        // flush with a simultaneous commit
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1, 0, 0, 32'(4 * i), 5'd1, 1, $urandom);
        cycle(1, 0, 1, 32'h300, 5'd1, 1, 32'h3);
        chk("flush_valid", 32'(bus.trace_valid), 32'd0);
        chk("flush_fill", 32'(fill_level), 32'd0);
        chk("flush_drop", 32'(drop_count), 32'd0);
        cycle(1, 0, 0, 32'h304, 5'd1, 1, 32'h4);
        chk("flush_nextseq", bus.trace_rec.seq, 32'd5);

        // asynchronous reset between edges while draining
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 32'(4 * i), 5'd1, 1, $urandom);
        cycle(0, 1, 0, 0, 0, 0, 0);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_valid", 32'(bus.trace_valid), 32'd0);
        chk("arst_fill", 32'(fill_level), 32'd0);
        chk_rec("arst_rec", bus.trace_rec, '0);
        bus.trace_ready = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        mq.delete();
        m_seq  = 0;
        m_drop = 0;
        cycle(1, 0, 0, 32'h400, 5'd1, 1, 32'h5);
        chk("arst_seq", bus.trace_rec.seq, 32'd0);

        // randomized traffic against the queue model
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            cycle($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 45,
                  $urandom_range(0, 99) < 2, $urandom, 5'($urandom_range(0, 31)),
                  1'($urandom), $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
